rti_pop_sequencer: RTL and testbench

// Return-side unwind unit. It is the reader for the interrupt/CALL push sequencer.
// On RET or RTI it pops the saved frame from the data-memory stack, one 16-bit word per cycle.
// It reassembles the 32-bit PC and, for RTI only, the 3-bit flag word.
// It then asserts a single-cycle load toward fetch, the flag register and the SP, and a flush toward the HDU.
// It sits beside MemoryStage and shares its synchronous-read data-memory port.

---
 rtl/rti_pop_sequencer.sv | 114 +++++++++++
 tb/tb_rti_pop_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rti_pop_sequencer.sv
// rtl/rti_pop_sequencer.sv - RET/RTI stack unwind: pops PC (and flags) from data memory
module rti_pop_sequencer #(
  parameter int ADDR_W = 12,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_rti,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              flush
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_FLAGS = 3'd1;
  localparam logic [2:0] RD_HI    = 3'd2;
  localparam logic [2:0] RD_LO    = 3'd3;
  localparam logic [2:0] CAP_LO   = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic              rti;
  logic [FLAG_W-1:0] flags_q;
  logic [15:0]       hi_q;

  // A request is taken when idle or on the completion cycle of the previous frame.
  logic accept;
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Sequencer state, frame base latch, partial-word capture and restored-value registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      rti       <= 1'b0;
      flags_q   <= '0;
      hi_q      <= '0;
      pc_out    <= '0;
      flags_out <= '0;
      sp_out    <= '0;
    end else begin
      case (state)
        RD_FLAGS: state <= RD_HI;
        RD_HI: begin
          // flags word requested in RD_FLAGS arrives now; only the low bits matter
          if (rti) flags_q <= rd_data[FLAG_W-1:0];
          state <= RD_LO;
        end
        RD_LO: begin
          hi_q  <= rd_data;
          state <= CAP_LO;
        end
        CAP_LO: begin
          // low half arrives now; publish the whole frame so it is valid during DONE
          pc_out <= PC_W'({hi_q, rd_data});
          sp_out <= base + (rti ? ADDR_W'(3) : ADDR_W'(2));
          if (rti) flags_out <= flags_q;
          state <= DONE;
        end
        default: begin
          // IDLE and DONE share the accept rules; in DONE the new base is the SP just restored
          if (accept) begin
            base  <= (state == DONE) ? sp_out : sp_in;
            rti   <= is_rti;
            state <= is_rti ? RD_FLAGS : RD_HI;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Moore outputs: read port drive, completion pulses and hazard signalling.
  always_comb begin
    rd_en      = 1'b0;
    rd_addr    = '0;
    busy       = (state != IDLE);
    stall      = (state != IDLE) || start;
    pc_load    = (state == DONE);
    sp_we      = (state == DONE);
    flush      = (state == DONE);
    flags_load = (state == DONE) && rti;
    case (state)
      RD_FLAGS: begin
        rd_en   = 1'b1;
        rd_addr = base + ADDR_W'(1);
      end
      RD_HI: begin
        rd_en   = 1'b1;
        rd_addr = base + (rti ? ADDR_W'(2) : ADDR_W'(1));
      end
      RD_LO: begin
        rd_en   = 1'b1;
        rd_addr = base + (rti ? ADDR_W'(3) : ADDR_W'(2));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rti_pop_sequencer.sv
// tb/tb_rti_pop_sequencer.sv - directed self-checking bench for rti_pop_sequencer
module tb_rti_pop_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_rti;
  logic [11:0] sp_in;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        flags_load;
  logic [2:0]  flags_out;
  logic        sp_we;
  logic [11:0] sp_out;
  logic        flush;

  logic [15:0] mem [0:4095];
  int pass_cnt = 0;
  int total    = 0;

  rti_pop_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_rti(is_rti), .sp_in(sp_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .stall(stall),
    .pc_load(pc_load), .pc_out(pc_out),
    .flags_load(flags_load), .flags_out(flags_out),
    .sp_we(sp_we), .sp_out(sp_out), .flush(flush)
  );

  always #5 clk = ~clk;

  // one-cycle synchronous-read data memory
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_rti = 1'b0; sp_in = '0; rd_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    step(); step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_sp_out", sp_out, 0);
    chk("rst_flags_out", flags_out, 0);
    reset = 1'b0;

    // ---------------- RET from 0x0F0 ----------------
    mem[12'h0F1] = 16'h0001; mem[12'h0F2] = 16'h2345;
    step(); start = 1'b1; is_rti = 1'b0; sp_in = 12'h0F0; #1;
    chk("ret_c0_stall", stall, 1);
    chk("ret_c0_busy", busy, 0);
    step(); start = 1'b0; #1;
    chk("ret_c1_busy", busy, 1);
    chk("ret_c1_rd_en", rd_en, 1);
    chk("ret_c1_addr", rd_addr, 12'h0F1);
    step(); #1;
    chk("ret_c2_addr", rd_addr, 12'h0F2);
    step(); #1;
    chk("ret_c3_rd_en", rd_en, 0);
    chk("ret_c3_pc_load", pc_load, 0);
    step(); #1;
    chk("ret_c4_pc_load", pc_load, 1);
    chk("ret_c4_pc_out", pc_out, 32'h00012345);
    chk("ret_c4_sp_out", sp_out, 12'h0F2);
    chk("ret_c4_sp_we", sp_we, 1);
    chk("ret_c4_flush", flush, 1);
    chk("ret_c4_flags_load", flags_load, 0);
    step(); #1;
    chk("ret_c5_pc_load", pc_load, 0);
    chk("ret_c5_busy", busy, 0);
    chk("ret_c5_pc_hold", pc_out, 32'h00012345);

    // ---------------- RTI from 0x0F0 ----------------
    mem[12'h0F1] = 16'h0005; mem[12'h0F2] = 16'h0000; mem[12'h0F3] = 16'h0040;
    step(); start = 1'b1; is_rti = 1'b1; sp_in = 12'h0F0; #1;
    step(); start = 1'b0; is_rti = 1'b0; #1;
    chk("rti_c1_addr", rd_addr, 12'h0F1);
    step(); #1;
    chk("rti_c2_addr", rd_addr, 12'h0F2);
    step(); #1;
    chk("rti_c3_addr", rd_addr, 12'h0F3);
    step(); #1;
    chk("rti_c4_pc_load", pc_load, 0);
    chk("rti_c4_busy", busy, 1);
    step(); #1;
    chk("rti_c5_pc_load", pc_load, 1);
    chk("rti_c5_pc_out", pc_out, 32'h00000040);
    chk("rti_c5_flags_out", flags_out, 3'b101);
    chk("rti_c5_flags_load", flags_load, 1);
    chk("rti_c5_sp_out", sp_out, 12'h0F3);
    chk("rti_c5_flush", flush, 1);
    step(); #1;
    chk("rti_c6_flags_load", flags_load, 0);
    chk("rti_c6_busy", busy, 0);

    // ---------------- RTI wrap from 0xFFE, flags upper bits ignored ----------------
    mem[12'hFFF] = 16'hABCE; mem[12'h000] = 16'h1234; mem[12'h001] = 16'h5678;
    step(); start = 1'b1; is_rti = 1'b1; sp_in = 12'hFFE; #1;
    step(); start = 1'b0; #1;
    chk("wrap_c1_addr", rd_addr, 12'hFFF);
    step(); #1;
    chk("wrap_c2_addr", rd_addr, 12'h000);
    step(); #1;
    chk("wrap_c3_addr", rd_addr, 12'h001);
    step(); step(); #1;
    chk("wrap_pc_out", pc_out, 32'h12345678);
    chk("wrap_sp_out", sp_out, 12'h001);
    chk("wrap_flags_out", flags_out, 3'b110);

    // ---------------- start while busy is ignored ----------------
    mem[12'h101] = 16'hDEAD; mem[12'h102] = 16'hBEEF;
    step(); start = 1'b1; is_rti = 1'b0; sp_in = 12'h100; #1;
    step(); start = 1'b0; #1;
    step(); start = 1'b1; is_rti = 1'b1; sp_in = 12'h200; #1;
    chk("ign_c2_addr", rd_addr, 12'h102);
    step(); start = 1'b0; is_rti = 1'b0; #1;
    chk("ign_c3_pc_load", pc_load, 0);
    step(); #1;
    chk("ign_c4_pc_load", pc_load, 1);
    chk("ign_c4_pc_out", pc_out, 32'hDEADBEEF);
    chk("ign_c4_sp_out", sp_out, 12'h102);
    step(); #1;
    chk("ign_c5_busy", busy, 0);
    chk("ign_c5_pc_load", pc_load, 0);
    step(); #1;
    chk("ign_c6_pc_load", pc_load, 0);
    chk("ign_c6_rd_en", rd_en, 0);

    // ---------------- back-to-back RET, second start in DONE ----------------
    mem[12'h301] = 16'h1111; mem[12'h302] = 16'h2222;
    mem[12'h303] = 16'h3333; mem[12'h304] = 16'h4444;
    step(); start = 1'b1; is_rti = 1'b0; sp_in = 12'h300; #1;
    step(); start = 1'b0; #1;
    step(); step(); step(); start = 1'b1; sp_in = 12'h555; #1;
    chk("b2b_c4_pc_load", pc_load, 1);
    chk("b2b_c4_pc_out", pc_out, 32'h11112222);
    chk("b2b_c4_stall", stall, 1);
    step(); start = 1'b0; #1;
    chk("b2b_c5_busy", busy, 1);
    chk("b2b_c5_addr", rd_addr, 12'h303);
    step(); #1;
    chk("b2b_c6_addr", rd_addr, 12'h304);
    step(); #1;
    chk("b2b_c7_pc_load", pc_load, 0);
    step(); #1;
    chk("b2b_c8_pc_load", pc_load, 1);
    chk("b2b_c8_pc_out", pc_out, 32'h33334444);
    chk("b2b_c8_sp_out", sp_out, 12'h304);

    // ---------------- reset in RD_LO of an RTI ----------------
    mem[12'h401] = 16'h0007; mem[12'h402] = 16'h9999; mem[12'h403] = 16'h8888;
    step(); start = 1'b1; is_rti = 1'b1; sp_in = 12'h400; #1;
    step(); start = 1'b0; is_rti = 1'b0; #1;
    step(); #1;
    step(); #1;
    chk("abort_rd_lo_addr", rd_addr, 12'h403);
    reset = 1'b1; #1;
    step(); #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_pc_out", pc_out, 0);
    chk("abort_sp_out", sp_out, 0);
    chk("abort_flags_out", flags_out, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      chk("abort_no_pulse", {29'd0, pc_load, flags_load, sp_we}, 0);
    end
    mem[12'h501] = 16'hCAFE; mem[12'h502] = 16'hF00D;
    step(); start = 1'b1; is_rti = 1'b0; sp_in = 12'h500; #1;
    step(); start = 1'b0; #1;
    chk("fresh_c1_addr", rd_addr, 12'h501);
    step(); step(); step(); #1;
    chk("fresh_c4_pc_load", pc_load, 1);
    chk("fresh_c4_pc_out", pc_out, 32'hCAFEF00D);
    chk("fresh_c4_sp_out", sp_out, 12'h502);
    chk("fresh_c4_flags_out", flags_out, 0);
    chk("fresh_c4_flags_load", flags_load, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
